// File: rtl/mure_pkg.sv
// rtl/mure_pkg.sv - shared widths, entry structs and FSM state enum for the MURE drain sequencer
//
// Contents:
//   XLEN, INST_LEN, ITYPE_LEN, CAUSE_LEN  field widths
//   uop_entry_s     per-lane FIFO head: pc, inst, itype
//   common_entry_s  common FIFO head: exception, interrupt, eret, cause, tval
//   sched_state_e   scheduler FSM states
package mure_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INST_LEN  = 32;
  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned CAUSE_LEN = 5;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [INST_LEN-1:0]  inst;
    logic [ITYPE_LEN-1:0] itype;
  } uop_entry_s;

  typedef struct packed {
    logic                 exception;
    logic                 interrupt;
    logic                 eret;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
  } common_entry_s;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/mure_lzc.sv
// rtl/mure_lzc.sv - lowest-set-bit finder returning a lane index and an empty flag
//
// Ports:
//   i_vec    in   Width  request vector
//   o_idx    out  IdxW   index of the lowest set bit (0 when empty)
//   o_empty  out  1      no bit set in i_vec
module mure_lzc #(
  parameter int unsigned Width = 2,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] i_vec,
  output logic [IdxW-1:0]  o_idx,
  output logic             o_empty
);

  // Scan from the top down so the last hit, the lowest bit, wins.
  always_comb begin
    o_idx = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IdxW'(i);
      end
    end
  end

  assign o_empty = ~|i_vec;

endmodule

// File: rtl/mure_scheduler.sv
// rtl/mure_scheduler.sv - drains common + per-lane retirement FIFOs into a program-ordered one-beat stream
//
// Optional feature macro: MURE_SCHED_ERR_EN (skip empty lanes and flag order_err_o instead of stalling)
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   flush_i                 abort the current group (highest priority)
//   cmn_empty_i/entry_i/mask_i, cmn_pop_o        common FIFO head and pop
//   uop_empty_i/entry_i, uop_pop_o               per-lane FIFO heads and one-hot pop
//   inst_valid_o, ready_i                        output beat handshake
//   iaddr_o, inst_data_o, itype_o                instruction fields of the beat
//   exception_o, interrupt_o, eret_o, cause_o, tval_o  trap fields, last beat only
//   last_o                                       last beat of the group
//   order_err_o                                  sticky lane-order error (MURE_SCHED_ERR_EN only)
module mure_scheduler
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           cmn_empty_i,
  input  common_entry_s                  cmn_entry_i,
  input  logic [NrRetiredInstr-1:0]      cmn_mask_i,
  output logic                           cmn_pop_o,
  input  logic [NrRetiredInstr-1:0]      uop_empty_i,
  input  uop_entry_s [NrRetiredInstr-1:0] uop_entry_i,
  output logic [NrRetiredInstr-1:0]      uop_pop_o,
  output logic                           inst_valid_o,
  input  logic                           ready_i,
  output logic [XLEN-1:0]                iaddr_o,
  output logic [INST_LEN-1:0]            inst_data_o,
  output logic [ITYPE_LEN-1:0]           itype_o,
  output logic                           exception_o,
  output logic                           interrupt_o,
  output logic                           eret_o,
  output logic [CAUSE_LEN-1:0]           cause_o,
  output logic [XLEN-1:0]                tval_o,
  output logic                           last_o
`ifdef MURE_SCHED_ERR_EN
  ,
  output logic                           order_err_o
`endif
);

  localparam int unsigned LaneW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

  sched_state_e               r_state, w_state_nxt;
  logic [NrRetiredInstr-1:0]  r_pending;
  common_entry_s              r_trap;

  logic                       r_valid;
  logic                       r_last;
  logic [XLEN-1:0]            r_iaddr;
  logic [INST_LEN-1:0]        r_inst;
  logic [ITYPE_LEN-1:0]       r_itype;
  common_entry_s              r_out_trap;

  logic [LaneW-1:0]           w_lane;
  logic                       w_lane_none;
  logic [NrRetiredInstr-1:0]  w_lane_oh;
  logic [NrRetiredInstr-1:0]  w_pending_clr;
  logic                       w_lane_last;
  logic                       w_slot_free;
  logic                       w_cmn_pop;
  logic                       w_beat;
  logic                       w_skip;

  mure_lzc #(
    .Width (NrRetiredInstr),
    .IdxW  (LaneW)
  ) u_lzc (
    .i_vec   (r_pending),
    .o_idx   (w_lane),
    .o_empty (w_lane_none)
  );

  assign w_slot_free   = !r_valid || ready_i;
  assign w_lane_oh     = NrRetiredInstr'(1) << w_lane;
  assign w_pending_clr = r_pending & ~w_lane_oh;
  assign w_lane_last   = (w_pending_clr == '0);

  // Every action, including the IDLE common pop, waits for a free output
  // slot so that a stalled beat freezes the whole block.
  always_comb begin
    w_state_nxt = r_state;
    w_cmn_pop   = 1'b0;
    w_beat      = 1'b0;
    w_skip      = 1'b0;
    if (flush_i) begin
      w_state_nxt = IDLE;
    end else if (w_slot_free) begin
      case (r_state)
        IDLE: begin
          if (!cmn_empty_i) begin
            w_cmn_pop = 1'b1;
            // A zero-mask group is consumed without emitting anything.
            if (|cmn_mask_i) begin
              w_state_nxt = EMIT;
            end
          end
        end
        EMIT: begin
          if (w_lane_none) begin
            w_state_nxt = IDLE;
          end else if (!uop_empty_i[w_lane]) begin
            w_beat = 1'b1;
            if (w_lane_last) begin
              w_state_nxt = IDLE;
            end
          end
`ifdef MURE_SCHED_ERR_EN
          else begin
            w_skip = 1'b1;
            if (w_lane_last) begin
              w_state_nxt = IDLE;
            end
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending  <= '0;
      r_trap     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_iaddr    <= '0;
      r_inst     <= '0;
      r_itype    <= '0;
      r_out_trap <= '0;
    end else if (flush_i) begin
      r_pending  <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_out_trap <= '0;
    end else begin
      if (w_cmn_pop) begin
        r_pending <= cmn_mask_i;
        r_trap    <= cmn_entry_i;
      end else if (w_beat || w_skip) begin
        r_pending <= w_pending_clr;
      end

      if (w_beat) begin
        r_valid    <= 1'b1;
        r_iaddr    <= uop_entry_i[w_lane].pc;
        r_inst     <= uop_entry_i[w_lane].inst;
        r_itype    <= uop_entry_i[w_lane].itype;
        r_last     <= w_lane_last;
        // Trap fields ride only on the closing beat of the group.
        r_out_trap <= w_lane_last ? r_trap : '0;
      end else if (w_slot_free) begin
        r_valid    <= 1'b0;
        r_last     <= 1'b0;
        r_out_trap <= '0;
      end
    end
  end

`ifdef MURE_SCHED_ERR_EN
  logic r_order_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_order_err <= 1'b0;
    end else if (!flush_i && w_skip) begin
      r_order_err <= 1'b1;
    end
  end

  assign order_err_o = r_order_err;
`endif

  assign cmn_pop_o    = w_cmn_pop;
  assign uop_pop_o    = w_beat ? w_lane_oh : '0;
  assign inst_valid_o = r_valid;
  assign last_o       = r_last;
  assign iaddr_o      = r_iaddr;
  assign inst_data_o  = r_inst;
  assign itype_o      = r_itype;
  assign exception_o  = r_out_trap.exception;
  assign interrupt_o  = r_out_trap.interrupt;
  assign eret_o       = r_out_trap.eret;
  assign cause_o      = r_out_trap.cause;
  assign tval_o       = r_out_trap.tval;

endmodule
